// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Aardvark memory port arbiter.
// MEM_ARB_DEBUG_EN adds the debug requester (id REQ_DBG).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

`ifdef MEM_ARB_DEBUG_EN
   localparam int NREQ = 3;
`else
   localparam int NREQ = 2;
`endif
   localparam int IDW = (NREQ > 2) ? 2 : 1;

   // Requester ids double as priority rank: higher id wins
   localparam int REQ_IF  = 0;
   localparam int REQ_DM  = 1;
   localparam int REQ_DBG = 2;

   localparam int MEM_LAT_MIN      = 1;
   localparam int MEM_LAT_MAX      = 4;
   localparam int STARVE_LIMIT_MAX = 15;
   localparam int LAT_W            = 2;
   localparam int STARVE_W         = 4;

   function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = IDW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: fixed priority by requester id, with the
// starvation flag forcing instruction fetch to win.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  logic            starve_i,
   output logic [NREQ-1:0] win_o
);

   always_comb begin
      win_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i]) win_o = NREQ'(1) << i;
      end
      if (starve_i && req_i[REQ_IF]) win_o = NREQ'(1) << REQ_IF;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch, data and (with MEM_ARB_DEBUG_EN) debug accesses onto the
// single memory port through an IDLE/ISSUE/WAIT sequencer; one access in flight.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [DW-1:0] if_data,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_valid,
   output logic [DW-1:0] dm_rdata,
`ifdef MEM_ARB_DEBUG_EN
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_valid,
   output logic [DW-1:0] dbg_rdata,
`endif
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          cpu_stall,
   output logic          busy
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..4");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > STARVE_LIMIT_MAX) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   logic [NREQ-1:0] req_vec;
   logic [NREQ-1:0] req_we;
   logic [NREQ-1:0] win;
   logic [AW-1:0]   req_addr  [NREQ];
   logic [DW-1:0]   req_wdata [NREQ];

   assign req_vec[REQ_IF]   = if_req;
   assign req_we[REQ_IF]    = 1'b0;
   assign req_addr[REQ_IF]  = if_addr;
   assign req_wdata[REQ_IF] = '0;
   assign req_vec[REQ_DM]   = dm_req;
   assign req_we[REQ_DM]    = dm_we;
   assign req_addr[REQ_DM]  = dm_addr;
   assign req_wdata[REQ_DM] = dm_wdata;
`ifdef MEM_ARB_DEBUG_EN
   assign req_vec[REQ_DBG]   = dbg_req;
   assign req_we[REQ_DBG]    = dbg_we;
   assign req_addr[REQ_DBG]  = dbg_addr;
   assign req_wdata[REQ_DBG] = dbg_wdata;
`endif

   arb_state_e          state_q;
   logic [IDW-1:0]      id_q;
   logic                we_q;
   logic [LAT_W-1:0]    lat_q;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [NREQ-1:0]     gnt_q;
   logic [NREQ-1:0]     valid_q;
   logic [DW-1:0]       rdata_q [NREQ];
   logic                mem_en_q, mem_we_q;
   logic [AW-1:0]       mem_addr_q;
   logic [DW-1:0]       mem_wdata_q;
   logic                starve_flag;
   logic                resp_fire;
   logic                arb_take;

   assign starve_flag = if_req && (starve_q >= STARVE_W'(STARVE_LIMIT));
   assign arb_take    = (state_q == ST_IDLE) && (|req_vec);

   mem_arb_pick u_pick (
      .req_i    (req_vec),
      .starve_i (starve_flag),
      .win_o    (win)
   );

   logic [AW-1:0] sel_addr;
   logic          sel_we;
   logic [DW-1:0] sel_wdata;

   always_comb begin
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            sel_addr  = req_addr[i];
            sel_we    = req_we[i];
            sel_wdata = req_wdata[i];
         end
      end
   end

   // Starvation count only matters while fetch is actually waiting
   always_comb begin
      starve_d = starve_q;
      if (!if_req) begin
         starve_d = '0;
      end else if (arb_take) begin
         if (win[REQ_IF])                 starve_d = '0;
         else if (starve_q != '1)         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) starve_q <= '0;
      else        starve_q <= starve_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         we_q        <= 1'b0;
         lat_q       <= '0;
         gnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         gnt_q    <= '0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_take) begin
                  state_q     <= ST_ISSUE;
                  id_q        <= onehot_to_idx(win);
                  we_q        <= sel_we;
                  gnt_q       <= win;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= sel_we;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
               lat_q   <= LAT_W'(MEM_LAT - 1);
            end
            ST_WAIT: begin
               if (lat_q == '0) state_q <= ST_IDLE;
               else             lat_q   <= lat_q - LAT_W'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Response is registered on the edge entering the lat_q==0 WAIT cycle
   assign resp_fire = ((state_q == ST_ISSUE) && (MEM_LAT == 1)) ||
                      ((state_q == ST_WAIT)  && (lat_q == LAT_W'(1)));

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
      always_ff @(posedge clk) begin
         if (!reset) begin
            valid_q[gi] <= 1'b0;
            rdata_q[gi] <= '0;
         end else begin
            valid_q[gi] <= resp_fire && (id_q == IDW'(gi));
            if (resp_fire && (id_q == IDW'(gi)) && !we_q) rdata_q[gi] <= mem_rdata;
         end
      end
   end

   assign if_gnt    = gnt_q[REQ_IF];
   assign if_valid  = valid_q[REQ_IF];
   assign if_data   = rdata_q[REQ_IF];
   assign dm_gnt    = gnt_q[REQ_DM];
   assign dm_valid  = valid_q[REQ_DM];
   assign dm_rdata  = rdata_q[REQ_DM];
`ifdef MEM_ARB_DEBUG_EN
   assign dbg_gnt   = gnt_q[REQ_DBG];
   assign dbg_valid = valid_q[REQ_DBG];
   assign dbg_rdata = rdata_q[REQ_DBG];
`endif
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign cpu_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default build): instance A at MEM_LAT=1
// driven from a vector table, instance B at MEM_LAT=3 for the reset-in-WAIT case.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic       a_if_req, a_if_gnt, a_if_valid;
   logic [7:0] a_if_addr, a_if_data;
   logic       a_dm_req, a_dm_we, a_dm_gnt, a_dm_valid;
   logic [7:0] a_dm_addr, a_dm_wdata, a_dm_rdata;
   logic       a_mem_en, a_mem_we, a_cpu_stall, a_busy;
   logic [7:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

   logic       b_if_req, b_if_gnt, b_if_valid;
   logic [7:0] b_if_addr, b_if_data;
   logic       b_dm_req, b_dm_we, b_dm_gnt, b_dm_valid;
   logic [7:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
   logic       b_mem_en, b_mem_we, b_cpu_stall, b_busy;
   logic [7:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STARVE_LIMIT(4)) u_a (
      .clk(clk), .reset(reset),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_valid(a_if_valid), .if_data(a_if_data),
      .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
      .dm_gnt(a_dm_gnt), .dm_valid(a_dm_valid), .dm_rdata(a_dm_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .cpu_stall(a_cpu_stall), .busy(a_busy)
   );

   mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .STARVE_LIMIT(4)) u_b (
      .clk(clk), .reset(reset),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_data(b_if_data),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_gnt(b_dm_gnt), .dm_valid(b_dm_valid), .dm_rdata(b_dm_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall), .busy(b_busy)
   );

   // Memory A: read data valid from the issue cycle, sampled one edge later
   logic [7:0] mem_a [256];
   assign a_mem_rdata = mem_a[a_mem_addr];
   always @(posedge clk) begin
      if (!reset) begin
         mem_a[8'h10] <= 8'hA5;
         mem_a[8'h11] <= 8'h5A;
         mem_a[8'h12] <= 8'h77;
      end else if (a_mem_en && a_mem_we) begin
         mem_a[a_mem_addr] <= a_mem_wdata;
      end
   end

   // Memory B: two pipeline stages so data is sampled on the third edge
   logic [7:0] mem_b [256];
   logic [7:0] b_pipe1, b_pipe2;
   assign b_mem_rdata = b_pipe2;
   always @(posedge clk) begin
      if (!reset) begin
         mem_b[8'h30] <= 8'hC3;
         b_pipe1      <= 8'h00;
         b_pipe2      <= 8'h00;
      end else begin
         if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
         b_pipe1 <= mem_b[b_mem_addr];
         b_pipe2 <= b_pipe1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // flg = {if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, cpu_stall, busy}
   typedef struct {
      logic       ifr;
      logic [7:0] ifa;
      logic       dmr;
      logic       dmw;
      logic [7:0] dma;
      logic [7:0] dmd;
      logic [7:0] flg;
      logic [7:0] e_ifd;
      logic [7:0] e_dmd;
      logic [7:0] e_addr;
   } vec_t;

   vec_t vt [19];

   function automatic logic [7:0] a_flags();
      return {a_if_gnt, a_if_valid, a_dm_gnt, a_dm_valid, a_mem_en, a_mem_we, a_cpu_stall, a_busy};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string exp_seq;
      int    g;
      int    cyc;
      logic [1:0] exp_g;

      // fetch A5, store 3C@80 vs fetch, reload 80, dm pulse while busy
      vt[ 0] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0010, 8'h00, 8'h00, 8'h00};
      vt[ 1] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'b1000_1011, 8'h00, 8'h00, 8'h10};
      vt[ 2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0100_0001, 8'hA5, 8'h00, 8'h10};
      vt[ 3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0000, 8'hA5, 8'h00, 8'h10};
      vt[ 4] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h80, 8'h3C, 8'b0000_0010, 8'hA5, 8'h00, 8'h10};
      vt[ 5] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h80, 8'h3C, 8'b0010_1111, 8'hA5, 8'h00, 8'h80};
      vt[ 6] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0001_0011, 8'hA5, 8'h00, 8'h80};
      vt[ 7] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0010, 8'hA5, 8'h00, 8'h80};
      vt[ 8] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 8'b1000_1011, 8'hA5, 8'h00, 8'h11};
      vt[ 9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0100_0001, 8'h5A, 8'h00, 8'h11};
      vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 8'b0000_0010, 8'h5A, 8'h00, 8'h11};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 8'b0010_1011, 8'h5A, 8'h00, 8'h80};
      vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0001_0001, 8'h5A, 8'h3C, 8'h80};
      vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0000, 8'h5A, 8'h3C, 8'h80};
      vt[14] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0010, 8'h5A, 8'h3C, 8'h80};
      vt[15] = '{1'b1, 8'h12, 1'b1, 1'b0, 8'h44, 8'h00, 8'b1000_1011, 8'h5A, 8'h3C, 8'h12};
      vt[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0100_0001, 8'h77, 8'h3C, 8'h12};
      vt[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0000, 8'h77, 8'h3C, 8'h12};
      vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'b0000_0000, 8'h77, 8'h3C, 8'h12};

      reset = 1'b0;
      a_if_req = 1'b0; a_if_addr = 8'h00; a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = 8'h00; a_dm_wdata = 8'h00;
      b_if_req = 1'b0; b_if_addr = 8'h00; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = 8'h00; b_dm_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk8("reset_a_flags", a_flags(), 8'h00);
      chk8("reset_a_addr", a_mem_addr, 8'h00);
      chk8("reset_a_wdata", a_mem_wdata, 8'h00);
      chk8("reset_a_ifdata", a_if_data, 8'h00);
      chk1("reset_b_busy", b_busy, 1'b0);
      chk1("reset_b_mem_en", b_mem_en, 1'b0);
      reset = 1'b1;

      for (int k = 0; k < 19; k++) begin
         a_if_req = vt[k].ifr; a_if_addr = vt[k].ifa;
         a_dm_req = vt[k].dmr; a_dm_we = vt[k].dmw; a_dm_addr = vt[k].dma; a_dm_wdata = vt[k].dmd;
         @(negedge clk);
         $display("vec %0d: flags=%b if_data=%h dm_rdata=%h mem_addr=%h", k, a_flags(), a_if_data, a_dm_rdata, a_mem_addr);
         chk8($sformatf("vec%0d_flags", k), a_flags(), vt[k].flg);
         chk8($sformatf("vec%0d_if_data", k), a_if_data, vt[k].e_ifd);
         chk8($sformatf("vec%0d_dm_rdata", k), a_dm_rdata, vt[k].e_dmd);
         chk8($sformatf("vec%0d_mem_addr", k), a_mem_addr, vt[k].e_addr);
         if (vt[k].flg[3]) chk8($sformatf("vec%0d_mem_wdata", k), a_mem_wdata, vt[k].dmd);
         @(posedge clk);
         #1;
      end

      // Starvation: dm held with fetch waiting -> 4 dm grants, then fetch, then again
      exp_seq = "DDDDIDDDDI";
      g = 0;
      cyc = 0;
      a_if_req = 1'b1; a_if_addr = 8'h21;
      a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 8'h20; a_dm_wdata = 8'h00;
      while (g < 10 && cyc < 200) begin
         @(negedge clk);
         if (a_if_gnt || a_dm_gnt) begin
            exp_g = (exp_seq[g] == "I") ? 2'b10 : 2'b01;
            $display("starve grant %0d: if_gnt=%b dm_gnt=%b", g, a_if_gnt, a_dm_gnt);
            chk8($sformatf("starve_grant%0d", g), {6'b0, a_if_gnt, a_dm_gnt}, {6'b0, exp_g});
            g++;
         end
         cyc++;
      end
      if (g < 10) begin
         n_cmp++;
         n_bad++;
         $display("FAIL starve_timeout: got %0d grants expected 10", g);
      end
      a_if_req = 1'b0;
      a_dm_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk1("starve_idle_busy", a_busy, 1'b0);

      // Reset asserted during WAIT on the MEM_LAT=3 instance
      b_if_req = 1'b1; b_if_addr = 8'h30;
      @(negedge clk);
      chk1("rst_k0_busy", b_busy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      $display("rst seq issue: gnt=%b mem_en=%b addr=%h", b_if_gnt, b_mem_en, b_mem_addr);
      chk1("rst_k1_gnt", b_if_gnt, 1'b1);
      chk1("rst_k1_mem_en", b_mem_en, 1'b1);
      chk8("rst_k1_addr", b_mem_addr, 8'h30);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk1("rst_k2_busy", b_busy, 1'b1);
      chk1("rst_k2_valid", b_if_valid, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      $display("rst seq after reset: busy=%b valid=%b addr=%h", b_busy, b_if_valid, b_mem_addr);
      chk1("rst_k3_busy", b_busy, 1'b0);
      chk1("rst_k3_valid", b_if_valid, 1'b0);
      chk1("rst_k3_gnt", b_if_gnt, 1'b0);
      chk1("rst_k3_mem_en", b_mem_en, 1'b0);
      chk8("rst_k3_addr", b_mem_addr, 8'h00);
      chk8("rst_k3_data", b_if_data, 8'h00);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("rst_k4_regnt", b_if_gnt, 1'b1);
      chk1("rst_k4_valid", b_if_valid, 1'b0);
      @(posedge clk); #1;
      b_if_req = 1'b0;
      @(negedge clk);
      chk1("rst_k5_valid", b_if_valid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("rst_k6_valid", b_if_valid, 1'b0);
      chk1("rst_k6_busy", b_busy, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      $display("rst seq response: valid=%b data=%h", b_if_valid, b_if_data);
      chk1("rst_k7_valid", b_if_valid, 1'b1);
      chk8("rst_k7_data", b_if_data, 8'hC3);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("rst_k8_busy", b_busy, 1'b0);
      chk1("rst_k8_valid", b_if_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
